// File: rtl/level_disp_pkg.sv
// Shared types and constants for the level display: FSM states, special
// segment patterns and the BCD width helper.
package level_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // ceil(w * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/seg7.sv
// BCD to seven-segment decoder, active-low, bit0=a .. bit6=g.
// Non-decimal codes decode to an unlit digit.
module seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] leds
);

    always_comb begin
        case (bcd)
            4'd0:    leds = 7'b1000000;
            4'd1:    leds = 7'b1111001;
            4'd2:    leds = 7'b0100100;
            4'd3:    leds = 7'b0110000;
            4'd4:    leds = 7'b0011001;
            4'd5:    leds = 7'b0010010;
            4'd6:    leds = 7'b0000010;
            4'd7:    leds = 7'b1111000;
            4'd8:    leds = 7'b0000000;
            4'd9:    leds = 7'b0010000;
            default: leds = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/level_hex_driver.sv
// Binary level to multi-digit seven-segment display: sequential double-dabble
// conversion, one-deep pending load, leading-zero blanking, overflow dashes, blink.
module level_hex_driver
    import level_disp_pkg::*;
#(
    parameter int LEVEL_W     = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int BLINK_HALF  = 25000000,
    parameter int BLINK_TIMES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LEVEL_W-1:0]      level,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [NUM_DIGITS*7-1:0] HEX,
    output logic                    busy,
    output logic                    done
);

    localparam int BCD_DIGITS = bcd_digits(LEVEL_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int MAXD       = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int CW         = (LEVEL_W > 1) ? $clog2(LEVEL_W) : 1;
    localparam int PW         = $clog2(2 * BLINK_TIMES + 1);
    localparam int BW         = $clog2(BLINK_HALF + 1);

    state_t                         r_state, w_next;
    logic [LEVEL_W-1:0]             r_bin;
    logic [BCD_W-1:0]               r_bcd;
    logic [CW-1:0]                  r_cnt;
    logic [LEVEL_W-1:0]             r_pend;
    logic                           r_pend_vld;
    logic [NUM_DIGITS-1:0][3:0]     r_dig;
    logic                           r_ovf;
    logic                           r_done;
    logic [PW-1:0]                  r_phase;
    logic [BW-1:0]                  r_bcnt;

    logic                           w_start;
    logic [LEVEL_W-1:0]             w_start_val;
    logic [BCD_W-1:0]               w_adj;
    logic                           w_unused_msb;
    logic [4*MAXD-1:0]              w_ext;
    logic                           w_ovf;
    logic [NUM_DIGITS-1:0]          w_lz;
    logic                           w_dark;
    logic [NUM_DIGITS-1:0][6:0]     w_seg;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (load) w_next = CONV;
            CONV:    if (r_cnt == CW'(LEVEL_W - 1)) w_next = COMMIT;
            COMMIT:  w_next = (r_pend_vld || load) ? CONV : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs; a load in COMMIT is newer than any pending value, so it wins
    always_comb begin
        busy        = (r_state != IDLE) || r_pend_vld;
        w_start     = ((r_state == IDLE) && load) ||
                      ((r_state == COMMIT) && (r_pend_vld || load));
        w_start_val = load ? level : r_pend;
    end

    // Double-dabble adjust: add 3 to every nibble >= 5 before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    assign w_unused_msb = w_adj[BCD_W-1];
    assign w_ext        = (4 * MAXD)'(r_bcd);

    always_comb begin
        w_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < MAXD; i++)
            if (w_ext[i*4 +: 4] != 4'd0) w_ovf = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_dig      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == COMMIT);
            if (w_start) begin
                r_bin      <= w_start_val;
                r_bcd      <= '0;
                r_cnt      <= '0;
                r_pend_vld <= 1'b0;
            end else if (load && r_state != IDLE) begin
                r_pend     <= level;
                r_pend_vld <= 1'b1;
            end
            if (r_state == CONV) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[LEVEL_W-1]};
                r_bin <= {r_bin[LEVEL_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == COMMIT) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= w_ext[i*4 +: 4];
                r_ovf <= w_ovf;
            end
        end
    end

    // Blink timer: odd phases are dark, phase 0 is steady
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
            r_bcnt  <= '0;
        end else if (r_state == COMMIT) begin
            r_phase <= blink_en ? PW'(2 * BLINK_TIMES) : '0;
            r_bcnt  <= '0;
        end else if (r_phase != '0) begin
            if (r_bcnt == BW'(BLINK_HALF - 1)) begin
                r_bcnt  <= '0;
                r_phase <= r_phase - 1'b1;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign done   = r_done;
    assign w_dark = blink_en && r_phase[0];

    // w_lz[i]: digit i and everything above it are zero
    always_comb begin
        logic v_all0;
        v_all0 = 1'b1;
        w_lz   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_all0  = v_all0 && (r_dig[i] == 4'd0);
            w_lz[i] = v_all0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            seg7 u_seg7 (.bcd(r_dig[g]), .leds(w_seg[g]));
            assign HEX[g*7 +: 7] = w_dark                         ? SEG_BLANK :
                                   r_ovf                          ? SEG_DASH  :
                                   (blank_lz && g > 0 && w_lz[g]) ? SEG_BLANK :
                                                                    w_seg[g];
        end
    endgenerate

endmodule

// File: tb/tb_level_hex_driver.sv
// Directed bench for level_hex_driver: 3-digit instance with a short blink
// timer plus a 2-digit instance for overflow.
module tb_level_hex_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
                           S7 = 7'b1111000, S9 = 7'b0010000,
                           SB = 7'b1111111, SD = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  level = '0, level1 = '0;
    logic        load = 1'b0, load1 = 1'b0;
    logic        blank_lz = 1'b1, blink_en = 1'b0;
    logic        blank_lz1 = 1'b0, blink_en1 = 1'b0;
    logic [20:0] HEX;
    logic [13:0] HEX1;
    logic        busy, done, busy1, done1;

    int checks = 0, failures = 0;

    level_hex_driver #(.LEVEL_W(8), .NUM_DIGITS(3), .BLINK_HALF(4), .BLINK_TIMES(2)) u_dut0 (
        .clk(clk), .reset(reset), .level(level), .load(load), .blank_lz(blank_lz),
        .blink_en(blink_en), .HEX(HEX), .busy(busy), .done(done));

    level_hex_driver #(.LEVEL_W(8), .NUM_DIGITS(2), .BLINK_HALF(4), .BLINK_TIMES(2)) u_dut1 (
        .clk(clk), .reset(reset), .level(level1), .load(load1), .blank_lz(blank_lz1),
        .blink_en(blink_en1), .HEX(HEX1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [7:0] v);
        level = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n;
        n = 0;
        while (((sel ? done1 : done) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk(tag, 0, 1);
    endtask

    initial begin
        int  nd;
        bit  seen34, gap, dark;

        reset = 1'b1;
        #2 reset = 1'b0;
        tick(); tick();
        chk("rst_hex", HEX, {SB, SB, S0});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();
        chk("rel_hex", HEX, {SB, SB, S0});
        chk("rel_busy", busy, 0);

        // 127: busy for 9 cycles, done at the 9th edge after load
        load_val(8'd127);
        chk("l127_busy0", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("l127_busy", {busy, done}, 2'b10);
        end
        tick();
        chk("l127_done", {busy, done}, 2'b01);
        chk("l127_hex", HEX, {S1, S2, S7});
        tick();
        chk("l127_done_clr", done, 0);

        load_val(8'd5);
        wait_done(0, "l5_timeout");
        chk("l5_blank", HEX, {SB, SB, S5});
        blank_lz = 1'b0;
        #1;
        chk("l5_noblank", HEX, {S0, S0, S5});

        // 12, then 34 and 56 during CONV: 34 overwritten by 56
        load_val(8'd12);
        tick(); tick();
        load_val(8'd34);
        load_val(8'd56);
        nd = 0; seen34 = 0; gap = 0;
        for (int k = 0; k < 40 && nd < 2; k++) begin
            tick();
            if (HEX == {S0, S3_dummy(), S4}) seen34 = 1;
            if (done) begin
                nd++;
                if (nd == 1) chk("pend_first12", HEX, {S0, S1, S2});
            end
            if (nd < 2 && !busy) gap = 1;
        end
        chk("pend_ndone", nd, 2);
        chk("pend_no34", seen34, 0);
        chk("pend_busy_gap", gap, 0);
        chk("pend_hex56", HEX, {S0, S5, S6});
        chk("pend_idle", busy, 0);

        // load arriving exactly in the COMMIT cycle is converted next
        load_val(8'd200);
        repeat (8) tick();
        level = 8'd99;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("cl_done", done, 1);
        chk("cl_hex200", HEX, {S2, S0, S0});
        chk("cl_busy", busy, 1);
        tick();
        wait_done(0, "cl_timeout");
        chk("cl_hex99", HEX, {S0, S9, S9});

        // 2-digit instance: overflow then recovery
        level1 = 8'd255;
        load1  = 1'b1;
        tick();
        load1  = 1'b0;
        wait_done(1, "ovf_timeout");
        chk("ovf_dash", HEX1, {SD, SD});
        level1 = 8'd42;
        load1  = 1'b1;
        tick();
        load1  = 1'b0;
        wait_done(1, "ovf42_timeout");
        chk("ovf_clear42", HEX1, {S4, S2});

        // reset mid-conversion discards everything
        blank_lz = 1'b1;
        load_val(8'd3);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rconv_hex", HEX, {SB, SB, S0});
        chk("rconv_busy", busy, 0);
        tick();
        reset = 1'b1;
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        chk("rconv_nodone", nd, 0);
        chk("rconv_hex_after", HEX, {SB, SB, S0});

        // blink: dark in samples 4..7 and 12..15 after the commit edge
        blink_en = 1'b1;
        load_val(8'd7);
        wait_done(0, "blink_timeout");
        chk("blink_k0", HEX, {SB, SB, S7});
        for (int k = 1; k <= 20; k++) begin
            tick();
            dark = (k >= 4 && k <= 7) || (k >= 12 && k <= 15);
            chk($sformatf("blink_k%0d", k), HEX, dark ? {SB, SB, SB} : {SB, SB, S7});
        end

        load_val(8'd7);
        wait_done(0, "blink2_timeout");
        repeat (5) tick();
        chk("blink2_dark", HEX, {SB, SB, SB});
        blink_en = 1'b0;
        #1;
        chk("blink_off_steady", HEX, {SB, SB, S7});
        blink_en = 1'b1;
        #1;
        chk("blink_on_dark", HEX, {SB, SB, SB});
        reset = 1'b0;
        #1;
        chk("blink_rst_hex", HEX, {SB, SB, S0});
        chk("blink_rst_done", done, 0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("blink_rst_steady", HEX, {SB, SB, S0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [6:0] S3_dummy();
        return 7'b0110000;
    endfunction

endmodule
